// File: rtl/fetch_prefetch_stage_if.sv
// Fetch-stage bus: IMem request/response, EX redirect and the decode handshake.
interface fetch_prefetch_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_ready;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        input  dec_ready,
        output if_valid, if_pc, if_instr
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        output dec_ready,
        input  if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/fetch_prefetch_stage.sv
// Instruction-fetch front end: PC, 1-cycle IMem request, prefetch FIFO, redirect squash.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_prefetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic clock,
    input  logic reset,
    fetch_prefetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_squashed
`endif
);

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [XLEN-1:0]  pc_mem    [BUF_DEPTH];
    logic [31:0]      instr_mem [BUF_DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             inflight_q;
    logic [XLEN-1:0]  inflight_pc_q;
    logic [XLEN-1:0]  fetch_pc_q;
    logic [XLEN-1:0]  last_pc_q;

    logic             head_valid_c;
    logic             pop_c;
    logic             wr_c;
    logic             issue_c;
    logic [OCC_W-1:0] occ_c;
    logic [XLEN-1:0]  target_c;
    logic [XLEN-1:0]  addr_c;
    logic             if_valid_c;
    logic [XLEN-1:0]  if_pc_c;
    logic [31:0]      if_instr_c;

    // Handshake, issue decision and head presentation
    always_comb begin
        head_valid_c = 1'b0;
        pop_c        = 1'b0;
        wr_c         = 1'b0;
        issue_c      = 1'b0;
        occ_c        = '0;
        target_c     = '0;
        addr_c       = fetch_pc_q;
        if_valid_c   = 1'b0;
        if_pc_c      = '0;
        if_instr_c   = NOP;

        head_valid_c = (count_q != '0);
        target_c     = bus.redirect_pc & ~XLEN'(3);
        pop_c        = !reset && head_valid_c && bus.dec_ready && !bus.redirect_valid;
        // The response of a squashed request is dropped on the redirect cycle.
        wr_c         = !reset && inflight_q && !bus.redirect_valid;
        occ_c        = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop_c);
        issue_c      = !reset && (bus.redirect_valid || (occ_c < OCC_W'(BUF_DEPTH)));
        addr_c       = bus.redirect_valid ? target_c : fetch_pc_q;

        if (!reset) begin
            if_valid_c = head_valid_c;
            if_pc_c    = head_valid_c ? pc_mem[head_q] : last_pc_q;
            if_instr_c = head_valid_c ? instr_mem[head_q] : NOP;
        end
    end

    assign bus.imem_req  = issue_c;
    assign bus.imem_addr = addr_c;
    assign bus.if_valid  = if_valid_c;
    assign bus.if_pc     = if_pc_c;
    assign bus.if_instr  = if_instr_c;

    // Control state: pointers, occupancy, outstanding request, PC
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            last_pc_q     <= '0;
        end else begin
            if (head_valid_c) begin
                last_pc_q <= pc_mem[head_q];
            end
            inflight_q <= issue_c;
            if (issue_c) begin
                inflight_pc_q <= addr_c;
            end
            if (bus.redirect_valid) begin
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
                fetch_pc_q <= target_c + XLEN'(4);
            end else begin
                if (issue_c) begin
                    fetch_pc_q <= fetch_pc_q + XLEN'(4);
                end
                if (wr_c) begin
                    tail_q <= tail_q + PTR_W'(1);
                end
                if (pop_c) begin
                    head_q <= head_q + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(wr_c) - CNT_W'(pop_c);
            end
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity
    always_ff @(posedge clock) begin
        if (wr_c) begin
            pc_mem[tail_q]    <= inflight_pc_q;
            instr_mem[tail_q] <= bus.imem_rdata;
        end
    end

    // The issue rule guarantees a free slot for every accepted response
    resp_never_full: assert property (@(posedge clock) disable iff (reset)
        !(wr_c && (count_q == CNT_W'(BUF_DEPTH))));

`ifdef FETCH_PERF_CNT_EN
    logic [32:0] squash_sum_c;

    always_comb begin
        squash_sum_c = '0;
        squash_sum_c = {1'b0, perf_squashed} + 33'(count_q) + 33'(inflight_q);
    end

    // Saturating event counters
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched  <= '0;
            perf_stalls   <= '0;
            perf_squashed <= '0;
        end else begin
            if (pop_c && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'(1);
            end
            if (if_valid_c && !bus.dec_ready && (perf_stalls != '1)) begin
                perf_stalls <= perf_stalls + 32'(1);
            end
            if (bus.redirect_valid) begin
                perf_squashed <= squash_sum_c[32] ? '1 : squash_sum_c[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Directed bench for fetch_prefetch_stage: queue-based reference model checked every cycle plus literal pins.
module tb_fetch_prefetch_stage;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   cyc;

    logic [31:0] imem [256];

    fetch_prefetch_stage_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
    logic [31:0] perf_squashed;
`endif

    fetch_prefetch_stage #(
        .XLEN      (32),
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stalls   (perf_stalls),
        .perf_squashed (perf_squashed)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous IMem, one-cycle read latency
    always @(posedge clock) begin
        if (bus.imem_req) bus.imem_rdata <= imem[bus.imem_addr[9:2]];
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    // Reference model: prefetch queue, one outstanding request, PC
    logic [31:0] q_pc [$];
    logic [31:0] q_in [$];
    logic        m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_fpc;
    logic [31:0] m_last;
    int unsigned m_fetched;
    int unsigned m_stalls;
    int unsigned m_squashed;

    always @(negedge clock) begin : model_chk
        logic        e_val;
        logic        e_req;
        logic        pop;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] tgt;
        int          occ;
`ifdef FETCH_PERF_CNT_EN
        chk("m_perf_fetched", perf_fetched, m_fetched);
        chk("m_perf_stalls", perf_stalls, m_stalls);
        chk("m_perf_squashed", perf_squashed, m_squashed);
`endif
        if (reset) begin
            chk("m_req_rst", 32'(bus.imem_req), 32'd0);
            chk("m_valid_rst", 32'(bus.if_valid), 32'd0);
            chk("m_pc_rst", bus.if_pc, 32'd0);
            chk("m_instr_rst", bus.if_instr, NOP);
            q_pc.delete();
            q_in.delete();
            m_infl     = 1'b0;
            m_infl_pc  = RESET_PC;
            m_fpc      = RESET_PC;
            m_last     = 32'd0;
            m_fetched  = 0;
            m_stalls   = 0;
            m_squashed = 0;
        end else begin
            e_val   = (q_pc.size() != 0);
            e_pc    = e_val ? q_pc[0] : m_last;
            e_instr = e_val ? q_in[0] : NOP;
            pop     = e_val && bus.dec_ready && !bus.redirect_valid;
            tgt     = {bus.redirect_pc[31:2], 2'b00};
            occ     = q_pc.size() + int'(m_infl) - int'(pop);
            e_req   = bus.redirect_valid || (occ < DEPTH);
            chk("m_valid", 32'(bus.if_valid), 32'(e_val));
            chk("m_pc", bus.if_pc, e_pc);
            chk("m_instr", bus.if_instr, e_instr);
            chk("m_req", 32'(bus.imem_req), 32'(e_req));
            if (e_req) chk("m_addr", bus.imem_addr, bus.redirect_valid ? tgt : m_fpc);

            if (e_val && !bus.dec_ready) m_stalls++;
            if (e_val) m_last = q_pc[0];
            if (bus.redirect_valid) begin
                m_squashed += q_pc.size() + int'(m_infl);
                q_pc.delete();
                q_in.delete();
                m_infl    = 1'b1;
                m_infl_pc = tgt;
                m_fpc     = tgt + 32'd4;
            end else begin
                if (pop) begin
                    void'(q_pc.pop_front());
                    void'(q_in.pop_front());
                    m_fetched++;
                end
                if (m_infl) begin
                    q_pc.push_back(m_infl_pc);
                    q_in.push_back(imem[m_infl_pc[9:2]]);
                end
                m_infl = e_req;
                if (e_req) begin
                    m_infl_pc = m_fpc;
                    m_fpc     = m_fpc + 32'd4;
                end
            end
        end
    end

    // Advance one cycle, apply inputs, let combinational outputs settle
    task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic dr);
        @(posedge clock);
        #1;
        cyc++;
        reset              = rst;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.dec_ready      = dr;
        #2;
    endtask

    task automatic reset_run();
        step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        cyc = -1;
    endtask

    initial begin
        logic [31:0] t1w [4];
        logic [19:0] pat;
        n_cmp = 0;
        n_bad = 0;
        cyc   = -100;
        for (int i = 0; i < 256; i++) imem[i] = 32'hA000_0000 + 32'(i);
        imem[0] = 32'h0050_0093;
        imem[1] = 32'h0030_0113;
        imem[2] = 32'h0020_81B3;
        imem[3] = 32'h4020_8233;
        t1w[0] = 32'h0050_0093;
        t1w[1] = 32'h0030_0113;
        t1w[2] = 32'h0020_81B3;
        t1w[3] = 32'h4020_8233;
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.dec_ready      = 1'b1;
        bus.imem_rdata     = 32'd0;

        // T1 stream
        reset_run();
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t1_addr0", bus.imem_addr, 32'h0);
        chk("t1_req0", 32'(bus.imem_req), 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1);
            chk("t1_valid", 32'(bus.if_valid), 32'd1);
            chk("t1_pc", bus.if_pc, 32'(i * 4));
            chk("t1_instr", bus.if_instr, t1w[i]);
        end

        // T2 backpressure, then T3 redirect, then T4 misaligned redirect on a full FIFO
        reset_run();
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t2_pc0", bus.if_pc, 32'h0);
        for (int i = 3; i <= 7; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            chk("t2_hold_pc", bus.if_pc, 32'h4);
            chk("t2_hold_instr", bus.if_instr, 32'h0030_0113);
            chk("t2_no_req", 32'(bus.imem_req), 32'd0);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t2_pc4", bus.if_pc, 32'h4);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t2_pc8", bus.if_pc, 32'h8);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t2_pcC", bus.if_pc, 32'hC);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 32'h20, 1'b1);
        chk("t3_addr", bus.imem_addr, 32'h20);
        chk("t3_req", 32'(bus.imem_req), 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t3_bubble", 32'(bus.if_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_stalls", perf_stalls, 32'd5);
        chk("t6_fetched", perf_fetched, 32'd5);
        chk("t6_squashed", perf_squashed, 32'd2);
`endif
        step(1'b0, 1'b0, 32'd0, 1'b0);
        chk("t3_tgt_pc", bus.if_pc, 32'h20);
        chk("t3_tgt_instr", bus.if_instr, 32'hA000_0008);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        chk("t4_full_no_req", 32'(bus.imem_req), 32'd0);
        chk("t4_hold_pc", bus.if_pc, 32'h20);
        step(1'b0, 1'b1, 32'h22, 1'b0);
        chk("t4_addr_aligned", bus.imem_addr, 32'h20);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t4_empty", 32'(bus.if_valid), 32'd0);
        chk("t4_empty_instr", bus.if_instr, NOP);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t4_tgt_pc", bus.if_pc, 32'h20);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t4_next_pc", bus.if_pc, 32'h24);

        // T5 reset mid-stream, then PC wrap through a redirect
        reset_run();
        repeat (6) step(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 6; i <= 7; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b1);
            chk("t5_rst_valid", 32'(bus.if_valid), 32'd0);
            chk("t5_rst_instr", bus.if_instr, 32'h13);
            chk("t5_rst_req", 32'(bus.imem_req), 32'd0);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t5_restart_addr", bus.imem_addr, RESET_PC);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t5_gap", 32'(bus.if_valid), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t5_first_pc", bus.if_pc, RESET_PC);
        chk("t5_first_instr", bus.if_instr, 32'h0050_0093);
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        chk("wrap_tgt", bus.imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_pc_top", bus.if_pc, 32'hFFFF_FFFC);
        chk("wrap_instr_top", bus.if_instr, 32'hA000_00FF);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_pc_zero", bus.if_pc, 32'h0);

        // Mixed backpressure with a redirect in the middle; model-checked only
        pat = 20'b1011_0011_1000_1101_0110;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (i == 10), 32'h40, pat[i]);
        end
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
